// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the decode-side valid/stall/redirect signals.
// master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] PC_plus_4_output;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, PC_plus_4_output,
        input  imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, PC_plus_4_output,
        output imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC owner, one outstanding imem read, accept->inst_valid in 2 cycles.
// Stall backpressure absorbed by a one-entry skid buffer (HOLD); redirect overrides stall and squashes.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_squash;
    logic        r_inst_valid;
    logic [31:0] r_inst_out;
    logic [31:0] r_pc4;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc4;

    logic        w_req;
    logic        w_accept;
    logic        w_consume;
    logic        w_can_load;
    logic [31:0] w_redirect_pc;

    // Request depends only on registered state (and reset), never on stall/redirect.
    assign w_req         = (r_state == S_FETCH) && !rst;
    assign w_accept      = w_req && bus.imem_ready;
    assign w_consume     = r_inst_valid && !bus.stall;
    assign w_can_load    = !r_inst_valid || w_consume;
    assign w_redirect_pc = bus.redirect_pc & ~32'h3;

    assign bus.imem_req         = w_req;
    assign bus.imem_addr        = {r_pc[31:2], 2'b00};
    assign bus.inst_valid       = r_inst_valid;
    assign bus.inst_out         = r_inst_out;
    assign bus.PC_plus_4_output = r_pc4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC & ~32'h3;
            r_inflight_pc <= 32'h0;
            r_squash      <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_inst_out    <= 32'h0;
            r_pc4         <= 32'h0;
            r_skid_inst   <= 32'h0;
            r_skid_pc4    <= 32'h0;
        end else if (bus.redirect) begin
            r_pc         <= w_redirect_pc;
            r_inst_valid <= 1'b0;
            r_skid_inst  <= 32'h0;
            r_skid_pc4   <= 32'h0;
            case (r_state)
                S_FETCH: begin
                    // A request accepted alongside the redirect still returns data; mark it stale.
                    if (w_accept) begin
                        r_inflight_pc <= r_pc;
                        r_squash      <= 1'b1;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_squash <= 1'b0;
                        r_state  <= S_FETCH;
                    end else begin
                        r_squash <= 1'b1;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end else begin
            if (w_consume) begin
                r_inst_valid <= 1'b0;
            end
            case (r_state)
                S_FETCH: begin
                    if (w_accept) begin
                        r_inflight_pc <= r_pc;
                        r_pc          <= r_pc + 32'd4;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (r_squash) begin
                            r_squash <= 1'b0;
                            r_state  <= S_FETCH;
                        end else if (w_can_load) begin
                            r_inst_valid <= 1'b1;
                            r_inst_out   <= bus.imem_rdata;
                            r_pc4        <= r_inflight_pc + 32'd4;
                            r_state      <= S_FETCH;
                        end else begin
                            r_skid_inst <= bus.imem_rdata;
                            r_skid_pc4  <= r_inflight_pc + 32'd4;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_consume) begin
                        r_inst_valid <= 1'b1;
                        r_inst_out   <= r_skid_inst;
                        r_pc4        <= r_skid_pc4;
                        r_state      <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model (expected fetch stream + presented queue).
// A second instance starts at 32'hFFFF_FFFC to exercise PC wrap.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_unit_if u_if ();
    fetch_unit_if u_if2 ();

    fetch_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (u_if2.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Reference model: next expected fetch address, the single outstanding
    // request, and the in-order queue of instructions owed to decode.
    logic [31:0] exp_pc;
    bit          pend_vld;
    bit          pend_kill;
    logic [31:0] pend_addr;
    int          pend_wait;
    bit          req_exp;
    ent_t        q[$];
    ent_t        e;

    initial begin
        u_if.imem_ready   = 1'b0;
        u_if.imem_rvalid  = 1'b0;
        u_if.imem_rdata   = 32'h0;
        u_if.stall        = 1'b0;
        u_if.redirect     = 1'b0;
        u_if.redirect_pc  = 32'h0;
        u_if2.imem_ready  = 1'b0;
        u_if2.imem_rvalid = 1'b0;
        u_if2.imem_rdata  = 32'h0;
        u_if2.stall       = 1'b0;
        u_if2.redirect    = 1'b0;
        u_if2.redirect_pc = 32'h0;
        exp_pc    = 32'h0;
        pend_vld  = 1'b0;
        pend_kill = 1'b0;
        pend_addr = 32'h0;
        pend_wait = 0;

        repeat (2) @(negedge clk);
        chk("rst_req",   {31'h0, u_if.imem_req},   32'h0);
        chk("rst_valid", {31'h0, u_if.inst_valid}, 32'h0);
        chk("rst_inst",  u_if.inst_out,            32'h0);
        chk("rst_pc4",   u_if.PC_plus_4_output,    32'h0);
        chk("rst_req2",  {31'h0, u_if2.imem_req},  32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Drive phase: the first cycles are a clean back-to-back fetch.
            u_if.imem_rvalid = pend_vld && (pend_wait == 0);
            u_if.imem_rdata  = !u_if.imem_rvalid ? $urandom :
                               (pend_kill ? 32'hDEADBEEF : memf(pend_addr));
            if (pend_vld && pend_wait > 0) pend_wait--;
            if (cyc < 12) begin
                u_if.imem_ready = 1'b1;
                u_if.stall      = 1'b0;
                u_if.redirect   = 1'b0;
            end else begin
                u_if.imem_ready = ($urandom_range(0, 9) < 7);
                u_if.stall      = ($urandom_range(0, 9) < 4);
                u_if.redirect   = ($urandom_range(0, 19) == 0);
            end
            u_if.redirect_pc = ($urandom_range(0, 3) == 0) ?
                               (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;

            @(negedge clk);
            req_exp = !pend_vld && (q.size() < 2);
            chk("req", {31'h0, u_if.imem_req}, {31'h0, req_exp});
            if (req_exp) chk("addr", u_if.imem_addr, exp_pc);
            chk("valid", {31'h0, u_if.inst_valid}, {31'h0, q.size() > 0});
            if (q.size() > 0) begin
                chk("inst", u_if.inst_out, q[0].inst);
                chk("pc4",  u_if.PC_plus_4_output, q[0].pc4);
            end

            if (q.size() > 0 && !u_if.stall) void'(q.pop_front());
            if (pend_vld && u_if.imem_rvalid) begin
                if (!pend_kill) begin
                    e.pc4  = pend_addr + 32'd4;
                    e.inst = memf(pend_addr);
                    q.push_back(e);
                end
                pend_vld = 1'b0;
            end
            if (req_exp && u_if.imem_ready) begin
                pend_vld  = 1'b1;
                pend_kill = 1'b0;
                pend_addr = exp_pc;
                exp_pc    = exp_pc + 32'd4;
                pend_wait = (cyc < 12) ? 0 : $urandom_range(0, 2);
            end
            if (u_if.redirect) begin
                q.delete();
                exp_pc = u_if.redirect_pc & ~32'h3;
                if (pend_vld) pend_kill = 1'b1;
            end

            @(posedge clk);
            #1;
        end

        // Wrap: fetch from 32'hFFFF_FFFC, then the next request is at 0.
        u_if.imem_rvalid = 1'b0;
        u_if.redirect    = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("wrap_rst_req", {31'h0, u_if2.imem_req}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        u_if2.imem_ready = 1'b1;
        @(negedge clk);
        chk("wrap_req0",  {31'h0, u_if2.imem_req}, 32'h1);
        chk("wrap_addr0", u_if2.imem_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        u_if2.imem_rvalid = 1'b1;
        u_if2.imem_rdata  = 32'h1234_5678;
        @(negedge clk);
        chk("wrap_wait_req", {31'h0, u_if2.imem_req}, 32'h0);
        @(posedge clk);
        #1;
        u_if2.imem_rvalid = 1'b0;
        @(negedge clk);
        chk("wrap_valid", {31'h0, u_if2.inst_valid}, 32'h1);
        chk("wrap_inst",  u_if2.inst_out, 32'h1234_5678);
        chk("wrap_pc4",   u_if2.PC_plus_4_output, 32'h0);
        chk("wrap_req1",  {31'h0, u_if2.imem_req}, 32'h1);
        chk("wrap_addr1", u_if2.imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues word reads to instruction memory over a request/response handshake. Fetched instructions and their PC+4 go to the decode side through a valid/stall interface, with a one-entry skid buffer so no response is lost under stall. A branch/jump redirect squashes in-flight and buffered work.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset (bits [1:0] ignored)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  read request valid
- imem_addr  out  32  word-aligned fetch address; bits [1:0] always 0
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid (only for an accepted request)
- imem_rdata  in  32  instruction word
- stall  in  1  downstream cannot consume this cycle
- redirect  in  1  branch/jump taken; overrides stall
- redirect_pc  in  32  new fetch address (bits [1:0] ignored)
- inst_valid  out  1  inst_out/PC_plus_4_output hold a valid instruction
- inst_out  out  32  fetched instruction
- PC_plus_4_output  out  32  fetch address of inst_out + 4

## Operation
- Registers: pc, inflight_pc, squash, state, output register (inst_valid, inst_out, PC_plus_4_output), and skid buffer (skid_inst, skid_pc4).
- Consume: the output is consumed in a cycle where inst_valid=1 and stall=0. The output register may load when inst_valid=0 or a consume happens.
- Request accept: imem_req && imem_ready.
- FETCH:
  - Drive imem_req=1 and imem_addr={pc[31:2],2'b00}.
  - On accept: inflight_pc<=pc, pc<=pc+4 (mod 2^32), go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with squash=1: drop the data, clear squash, go to FETCH.
  - On imem_rvalid with squash=0:
    - If the output register can load: load inst_out<=imem_rdata, PC_plus_4_output<=inflight_pc+4, inst_valid<=1; go to FETCH.
    - Otherwise: write the skid buffer and go to HOLD.
- HOLD:
  - imem_req=0.
  - When a consume happens: move the skid buffer into the output register (inst_valid stays 1) and go to FETCH.
- Consume without reload: inst_valid<=0.
- redirect=1 has highest priority, in any state:
  - pc<=redirect_pc with [1:0] cleared; inst_valid<=0; skid buffer discarded.
  - FETCH with accept in the same cycle: squash<=1, go to WAIT.
  - FETCH without accept: stay in FETCH.
  - WAIT with rvalid in the same cycle: the data is dropped, go to FETCH, squash<=0.
  - WAIT without rvalid: squash<=1, stay in WAIT.
  - HOLD: go to FETCH.
- Exactly one request is outstanding at most. imem_rvalid outside WAIT is ignored.

## Timing
- Reset values (async, immediate): state=FETCH, pc=RESET_PC, squash=0, inst_valid=0, inst_out=0, PC_plus_4_output=0, skid=0, inflight_pc=0. imem_req=0 while rst=1.
- imem_req and imem_addr are functions of registered state only; there is no combinational path from stall or redirect.
- Minimum latency is accept at cycle N, rvalid at N+1, inst_valid at N+2. Peak throughput is one instruction per 2 cycles.
- Redirect asserted at cycle N: inst_valid=0 at N+1. The earliest request to redirect_pc is issued at N+1 if no request is in flight; otherwise it follows the squashed response.
- stall has no effect while inst_valid=0.
- Reset mid-WAIT: the pending response is ignored because state is FETCH.
- PC wraps from 32'hFFFF_FFFC to 0. PC_plus_4_output wraps the same way.

## Test plan
- Reset release, RESET_PC=0, ready=1, rvalid one cycle after accept, no stall -> requests to addresses 0,4,8. Outputs inst_valid with PC_plus_4_output 4,8,12 and the matching inst_out, 2 cycles apart.
- Memory holds ready=0 for 3 cycles -> imem_req=1 and imem_addr stable for those 3 cycles; pc is not advanced.
- stall=1 while inst_valid=1 and a second response arrives -> the block enters HOLD and issues no new request. Dropping stall presents the first then the second instruction (PC+4 4 then 8) in order, with none lost.
- redirect to 32'h100 in WAIT, rvalid the next cycle with 32'hDEADBEEF -> that data is never presented. The next request uses address 32'h100, and its output has PC_plus_4_output=32'h104.
- redirect together with stall while in HOLD -> inst_valid=0 the next cycle, the skid buffer is discarded, and the fetch from redirect_pc proceeds.
- Start at RESET_PC=32'hFFFF_FFFC -> the second request uses address 0, and the first output has PC_plus_4_output=0.
